// File: rtl/fetch_sequencer.sv
// Program counter and fetch control: steps/redirects the PC and runs the
// start/done handshake with the harness.
module fetch_sequencer #(
    parameter int PC_W       = 10,
    parameter int CNT_W      = 16,
    parameter int PROG0_BASE = 0,
    parameter int PROG1_BASE = 256,
    parameter int PROG2_BASE = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             branch,
    input  logic [PC_W-1:0]  target,
    input  logic             halt,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  BASE0   = PROG0_BASE[PC_W-1:0];
    localparam logic [PC_W-1:0]  BASE1   = PROG1_BASE[PC_W-1:0];
    localparam logic [PC_W-1:0]  BASE2   = PROG2_BASE[PC_W-1:0];
    localparam logic [PC_W-1:0]  PC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic [PC_W-1:0]  base;

    always_comb begin
        base = BASE0;
        unique case (prog_sel)
            2'd1:    base = BASE1;
            2'd2:    base = BASE2;
            default: base = BASE0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start && prog_sel != 2'd3) begin
                    pc_d    = base;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // halt > stall > branch > wrap > step
                if (halt) begin
                    state_d = DONE;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch) begin
                    pc_d = target;
                end else if (pc_q == PC_MAX) begin
                    pc_d    = '0;
                    ovr_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_en    = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign overrun     = ovr_q;
    assign cycle_count = cnt_q;

endmodule
